// File: rtl/template_scan.sv
// template_scan: streams DEPTH 1-bit locations out of a template ROM and an
// image bitmap that share one read address. It counts the addresses where the
// two bits agree and reports that count with a threshold decision.
//
// Ports
//   clk, rst_n        clock and asynchronous active-low reset
//   start             begin one scan (only sampled while idle)
//   mem_ad, mem_ce    shared read address and clock-enable for both memories
//   mem_oce           memory output-register enable, tied high (bypass mode)
//   rom_bit, img_bit  read data, valid the cycle after the address is captured
//   busy              high from the start-accepting edge through the done cycle
//   done              one-cycle pulse when score/match take a new value
//   score, match      agreement count and (score >= THRESH) of the last scan
module template_scan #(
  parameter int DEPTH  = 2560,
  parameter int ADDR_W = 12,
  parameter int THRESH = 2300
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_ad,
  output logic              mem_ce,
  output logic              mem_oce,
  input  logic              rom_bit,
  input  logic              img_bit,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   score,
  output logic              match
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_AD = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   THR     = (ADDR_W + 1)'(THRESH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ad_q, ad_d;
  logic                ce_q, ce_d;
  logic                ce_d1_q, ce_d1_d;   // marks cycles where rom/img data is valid
  logic [ADDR_W:0]     acc_q, acc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W:0]     score_q, score_d;
  logic                match_q, match_d;
  logic                hit;
  logic [ADDR_W:0]     acc_sum;

  always_comb begin
    hit     = ce_d1_q & ~(rom_bit ^ img_bit);
    acc_sum = acc_q + (ADDR_W + 1)'(hit);
    state_d = state_q;
    ad_d    = ad_q;
    ce_d    = ce_q;
    ce_d1_d = ce_q;
    acc_d   = acc_sum;
    busy_d  = busy_q;
    done_d  = 1'b0;
    score_d = score_q;
    match_d = match_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          ad_d    = '0;
          ce_d    = 1'b1;
          acc_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (ad_q == LAST_AD) begin
          state_d = DRAIN;
          ad_d    = '0;
          ce_d    = 1'b0;
        end else begin
          ad_d = ad_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        // The last address's data is in flight for exactly one cycle here;
        // acc_sum already includes it, so publish directly from the sum.
        state_d = DONE;
        done_d  = 1'b1;
        score_d = acc_sum;
        match_d = (acc_sum >= THR);
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ad_q    <= '0;
      ce_q    <= 1'b0;
      ce_d1_q <= 1'b0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      score_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ad_q    <= ad_d;
      ce_q    <= ce_d;
      ce_d1_q <= ce_d1_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      score_q <= score_d;
      match_q <= match_d;
    end
  end

  assign mem_ad  = ad_q;
  assign mem_ce  = ce_q;
  assign mem_oce = 1'b1;
  assign busy    = busy_q;
  assign done    = done_q;
  assign score   = score_q;
  assign match   = match_q;

endmodule

// File: tb/tb_template_scan.sv
// Bench for template_scan: synchronous-read memory models and a cycle-level
// reference built from elapsed time since start was accepted.
module tb_template_scan;
  localparam int DEPTH  = 2560;
  localparam int ADDR_W = 12;
  localparam int THRESH = 2300;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] mem_ad;
  logic              mem_ce, mem_oce;
  logic              rom_bit = 1'b0, img_bit = 1'b0;
  logic              busy, done, match;
  logic [ADDR_W:0]   score;

  bit rom_mem [DEPTH];
  bit img_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  template_scan #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .THRESH(THRESH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_ad(mem_ad), .mem_ce(mem_ce), .mem_oce(mem_oce),
    .rom_bit(rom_bit), .img_bit(img_bit),
    .busy(busy), .done(done), .score(score), .match(match)
  );

  always #5 clk = ~clk;

  // Both memories register their read data on an enabled edge.
  always @(posedge clk) begin
    if (mem_ce) begin
      rom_bit <= rom_mem[mem_ad];
      img_bit <= img_mem[mem_ad];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: t = rising edges since the start-accepting edge (-1 when idle).
  // Address t is presented after edge t; the result appears after edge DEPTH+1.
  int t = -1;
  int m_cnt = 0;
  int e_score = 0;
  int e_match = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = -1; e_score = 0; e_match = 0;
    end else if (t < 0) begin
      if (start) begin
        t = 0;
        m_cnt = 0;
        for (int i = 0; i < DEPTH; i++) if (rom_mem[i] == img_mem[i]) m_cnt++;
      end
    end else begin
      t++;
      if (t == DEPTH + 1) begin
        e_score = m_cnt;
        e_match = (m_cnt >= THRESH) ? 1 : 0;
      end
      if (t == DEPTH + 2) t = -1;
    end
  end

  always @(negedge clk) begin
    chk("busy",    int'(busy),    (t >= 0 && t <= DEPTH + 1) ? 1 : 0);
    chk("mem_ce",  int'(mem_ce),  (t >= 0 && t < DEPTH) ? 1 : 0);
    chk("mem_ad",  int'(mem_ad),  (t >= 0 && t < DEPTH) ? t : 0);
    chk("done",    int'(done),    (t == DEPTH + 1) ? 1 : 0);
    chk("score",   int'(score),   e_score);
    chk("match",   int'(match),   e_match);
    chk("mem_oce", int'(mem_oce), 1);
  end

  // One scan; exp_score < 0 means "model only". repulse re-asserts start at
  // scan cycle 100 and again in the done cycle.
  task automatic run_scan(input int exp_score, input int exp_match, input bit repulse);
    int n;
    bit got;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    n = 0; got = 1'b0;
    while (n < 3000) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        start = repulse;
        break;
      end
      start = repulse && (n == 100);
      @(posedge clk);
      n++;
    end
    @(negedge clk) start = 1'b0;
    chk("done_seen", int'(got), 1);
    chk("latency", n, 2561);
    if (exp_score >= 0) begin
      chk("score_lit", int'(score), exp_score);
      chk("match_lit", int'(match), exp_match);
    end
    chk("busy_after", int'(busy), 0);
    repeat (4) @(negedge clk);
    if (exp_score >= 0) chk("score_held", int'(score), exp_score);
  endtask

  task automatic fill_same_ones();
    for (int i = 0; i < DEPTH; i++) begin rom_mem[i] = 1'b1; img_mem[i] = 1'b1; end
  endtask

  task automatic fill_random_copy();
    for (int i = 0; i < DEPTH; i++) begin
      rom_mem[i] = bit'($urandom_range(0, 1));
      img_mem[i] = rom_mem[i];
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"},  int'(busy),   0);
    chk({tag, "_ce"},    int'(mem_ce), 0);
    chk({tag, "_ad"},    int'(mem_ad), 0);
    chk({tag, "_done"},  int'(done),   0);
    chk({tag, "_score"}, int'(score),  0);
    chk({tag, "_match"}, int'(match),  0);
    chk({tag, "_oce"},   int'(mem_oce), 1);
  endtask

  initial begin
    int k;
    #1 reset_checks("rst0");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // All ones on both sides.
    fill_same_ones();
    run_scan(2560, 1, 1'b0);

    // Image is the inverse of the template.
    fill_random_copy();
    for (int i = 0; i < DEPTH; i++) img_mem[i] = ~rom_mem[i];
    run_scan(0, 0, 1'b0);

    // Differences only at the two boundary addresses.
    fill_random_copy();
    img_mem[0] = ~rom_mem[0];
    img_mem[DEPTH-1] = ~rom_mem[DEPTH-1];
    run_scan(2558, 1, 1'b0);

    // Threshold edge: 261 then 260 differing addresses.
    fill_random_copy();
    for (int i = 0; i < 261; i++) img_mem[i*9] = ~rom_mem[i*9];
    run_scan(2299, 0, 1'b0);
    fill_random_copy();
    for (int i = 0; i < 260; i++) img_mem[i*9] = ~rom_mem[i*9];
    run_scan(2300, 1, 1'b0);

    // Spurious start during the scan and in the done cycle.
    fill_random_copy();
    img_mem[0] = ~rom_mem[0];
    img_mem[DEPTH-1] = ~rom_mem[DEPTH-1];
    run_scan(2558, 1, 1'b1);

    // Asynchronous reset in the middle of a scan, then a full scan.
    fill_same_ones();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 0;
    while (mem_ad != ADDR_W'(1000) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("reach_ad1000", (k < 3000) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1 reset_checks("rst_mid");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_scan(2560, 1, 1'b0);

    // Random densities, checked against the reference only.
    for (int r = 0; r < 3; r++) begin
      int p;
      p = $urandom_range(0, 20);
      for (int i = 0; i < DEPTH; i++) begin
        rom_mem[i] = bit'($urandom_range(0, 1));
        img_mem[i] = rom_mem[i] ^ ($urandom_range(0, 99) < p);
      end
      run_scan(-1, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/template_scan.md
TEMPLATE_SCAN -- requirements
Module: template_scan

Interface
REQ-001 Parameter: DEPTH, default 2560, number of 1-bit template locations scanned (addresses 0..DEPTH-1).
REQ-002 Parameter: ADDR_W, default 12, memory address width; DEPTH SHALL be <= 2^ADDR_W.
REQ-003 Parameter: THRESH, default 2300, minimum match count for a positive match.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request to begin one scan, sampled only in IDLE.
REQ-007 mem_ad  output  ADDR_W  read address shared by template ROM and image bitmap memory.
REQ-008 mem_ce  output  1  read clock-enable for both memories.
REQ-009 mem_oce  output  1  output-register enable, constant 1 (bypass read mode).
REQ-010 rom_bit  input  1  template ROM data, valid the cycle after the edge that captured mem_ad with mem_ce=1.
REQ-011 img_bit  input  1  binarized image data, same timing as rom_bit.
REQ-012 busy  output  1  high from the start-accepting edge until done deasserts.
REQ-013 done  output  1  one-cycle pulse when score/match are updated.
REQ-014 score  output  ADDR_W+1  count of addresses where rom_bit == img_bit in the last completed scan.
REQ-015 match  output  1  score >= THRESH for the last completed scan.

Function
REQ-016 FSM states SHALL be IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on start; SCAN->DRAIN on the edge after mem_ad = DEPTH-1 is presented; DRAIN->DONE after the last bit is accumulated; DONE->IDLE after one cycle.
REQ-017 On the start-accepting edge: mem_ad=0, mem_ce=1, accumulator=0, busy=1.
REQ-018 In SCAN, mem_ce SHALL be 1 and mem_ad SHALL increment by 1 per cycle, no gaps, no repeats.
REQ-019 mem_ce SHALL be 0 in IDLE, DRAIN and DONE; mem_ad SHALL return to 0 when leaving SCAN.
REQ-020 A one-cycle-delayed copy of mem_ce SHALL qualify rom_bit/img_bit; the accumulator SHALL add 1 on each qualified edge where rom_bit == img_bit.
REQ-021 Accumulator width ADDR_W+1; no saturation or wrap occurs for DEPTH <= 2^ADDR_W.
REQ-022 score and match SHALL be loaded on the DRAIN->DONE edge, including the final bit (address DEPTH-1), and held unchanged until the next DONE.
REQ-023 Latency: done high in the cycle following the (DEPTH+1)th rising edge after the start-accepting edge (DEPTH=2560 -> 2561 edges).
REQ-024 start while not IDLE (including the DONE cycle) SHALL be ignored without side effects.
REQ-025 score/match SHALL not change during SCAN or DRAIN; the previous result remains readable while busy.

Reset
REQ-026 rst_n low SHALL immediately, regardless of clk: state=IDLE, mem_ad=0, mem_ce=0, busy=0, done=0, score=0, match=0, accumulator=0; mem_oce stays 1.
REQ-027 Reset mid-scan SHALL abort with no done pulse; the first start after rst_n release SHALL perform a complete scan from address 0.

Verification
REQ-028 ROM and image models all ones, start pulse -> mem_ad 0..2559 contiguous, done exactly 2561 edges after start edge, score=2560, match=1, busy low after done.
REQ-029 Image = bitwise inverse of ROM -> score=0, match=0, one done pulse.
REQ-030 Image differs from ROM only at addresses 0 and 2559 -> score=2558, match=1 (boundary addresses counted).
REQ-031 Image differs at 261 addresses -> score=2299, match=0; at 260 addresses -> score=2300, match=1 (threshold edge).
REQ-032 start re-pulsed at scan cycle 100 and in the DONE cycle -> ignored: address sequence uninterrupted, exactly one done, score unchanged afterwards.
REQ-033 rst_n asserted when mem_ad=1000 -> all outputs at reset values asynchronously, no done; after release, new start yields the full correct score of REQ-028.
